// File: rtl/segment_scanner.sv
// ============================================================================
// Module   : segment_scanner
// Brief    : Multiplexed common-anode 7-seg+dp scanner with ghost-guard
//            blanking and frame-aligned double-buffered updates.
//            Optional macro: SEGMENT_SCANNER_LZS_EN (leading-zero suppression).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_scanner #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [4*DIGITS-1:0]   upd_data_i,
  input  logic [DIGITS-1:0]     upd_dp_i,
  input  logic                  blank_i,
  input  logic                  lzs_en_i,
  output logic [DIGITS-1:0]     sel_o,
  output logic [7:0]            seg_o,
  output logic                  frame_done_o
);

  localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int                 c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  logic [c_DIV_W-1:0]  div_q, div_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                fd_q, fd_d;

  logic                w_slot_end;
  logic                w_boundary;
  logic                w_xfer;
  logic                w_guard_done;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_sup;
  logic [DIGITS-1:0]   w_lzs_mask;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] r;
    case (nib)
      4'h0: r = 7'h01;
      4'h1: r = 7'h4F;
      4'h2: r = 7'h12;
      4'h3: r = 7'h06;
      4'h4: r = 7'h4C;
      4'h5: r = 7'h24;
      4'h6: r = 7'h20;
      4'h7: r = 7'h0F;
      4'h8: r = 7'h00;
      4'h9: r = 7'h04;
      4'hA: r = 7'h08;
      4'hB: r = 7'h60;
      4'hC: r = 7'h31;
      4'hD: r = 7'h42;
      4'hE: r = 7'h30;
      default: r = 7'h38;
    endcase
    return r;
  endfunction

  assign w_slot_end  = (div_q == c_DIV_LAST);
  assign w_boundary  = w_slot_end && (idx_q == c_IDX_LAST);
  assign w_xfer      = upd_valid_i && !pend_q;
  assign upd_ready_o = !pend_q;
  assign sel_o        = sel_q;
  assign seg_o        = seg_q;
  assign frame_done_o = fd_q;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign w_guard_done = 1'b1;
    end else begin : g_guard
      assign w_guard_done = (div_q >= c_DIV_W'(BLANK_CYCLES));
    end
  endgenerate

`ifdef SEGMENT_SCANNER_LZS_EN
  // Suppression propagates downward from the MSD while nibbles stay zero.
  logic w_zero_run;
  always_comb begin
    w_lzs_mask = '0;
    w_zero_run = lzs_en_i;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_run    = w_zero_run && (act_data_q[4*i +: 4] == 4'h0);
      w_lzs_mask[i] = w_zero_run;
    end
  end
`else
  logic w_unused_lzs;
  assign w_lzs_mask   = '0;
  assign w_unused_lzs = lzs_en_i;
`endif

  always_comb begin
    div_d = w_slot_end ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (w_slot_end) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A transfer in a boundary cycle lands in pending, so it waits a full frame.
  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    if (w_boundary && pend_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      pend_d     = 1'b0;
    end else if (w_xfer) begin
      pend_data_d = upd_data_i;
      pend_dp_d   = upd_dp_i;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_sup    = 1'b0;
    w_lit    = w_guard_done && !blank_i;
    sel_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == c_IDX_W'(i)) begin
        w_nib    = act_data_q[4*i +: 4];
        w_dp_bit = act_dp_q[i];
        w_sup    = w_lzs_mask[i];
        sel_d[i] = w_lit;
      end
    end
    seg_d = 8'hFF;
    if (w_lit) begin
      seg_d = {(w_sup ? 7'h7F : seg_decode(w_nib)), ~w_dp_bit};
    end
    fd_d = w_boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      sel_q       <= '0;
      seg_q       <= 8'hFF;
      fd_q        <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      fd_q        <= fd_d;
    end
  end

endmodule

`default_nettype wire
